// File: rtl/sprite_scaler.sv
// Integer-scaled sprite overlay with double-buffered texel banks and colour key.
// Stage 1 registers window/address, stage 2 reads the front bank into outputs.
module sprite_scaler #(
    parameter int SPR_W   = 40,
    parameter int SPR_H   = 40,
    parameter int CW      = 4,
    parameter int SCALE_W = 4
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic                           PIX_VALID,
    input  logic                           FRAME_START,
    input  logic [9:0]                     X_VGA,
    input  logic [9:0]                     Y_VGA,
    input  logic [9:0]                     X_OBJETO,
    input  logic [9:0]                     Y_OBJETO,
    input  logic [SCALE_W-1:0]             MULTIPLICADOR,
    input  logic                           FLIP_H,
    input  logic                           TRANSP_EN,
    input  logic [3*CW-1:0]                TRANSP_KEY,
    input  logic                           WR_EN,
    input  logic [$clog2(SPR_W*SPR_H)-1:0] WR_ADDR,
    input  logic [3*CW-1:0]                WR_DATA,
    input  logic                           SWAP_REQ,
    output logic [CW-1:0]                  R_VGA,
    output logic [CW-1:0]                  G_VGA,
    output logic [CW-1:0]                  B_VGA,
    output logic                           HIT,
    output logic                           SWAP_PENDING
);
    localparam int N    = SPR_W * SPR_H;
    localparam int AW   = $clog2(N);
    localparam int TW   = 3 * CW;
    localparam int COLW = $clog2(SPR_W + 1);
    localparam int ROWW = $clog2(SPR_H + 1);

    logic [TW-1:0] bank0 [N];
    logic [TW-1:0] bank1 [N];

    logic [9:0]         xs_q, xs_d, ys_q, ys_d;
    logic [SCALE_W-1:0] m_q, m_d;
    logic               flip_q, flip_d, ten_q, ten_d;
    logic [TW-1:0]      key_q, key_d;
    logic               frame_ok_q, frame_ok_d;
    logic               front_q, front_d, pend_q, pend_d;
    logic [COLW-1:0]    col_q, col_d;
    logic [ROWW-1:0]    row_q, row_d;
    logic [SCALE_W-1:0] csub_q, csub_d, rsub_q, rsub_d;
    logic [9:0]         line_y_q, line_y_d;
    logic               line_seen_q, line_seen_d;
    logic               win_q, win_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [TW-1:0]      rgb_q, rgb_d;
    logic               hit_q, hit_d;

    logic [10:0]        x11, y11, xs11, ys11, span_x, span_y;
    logic [SCALE_W-1:0] m_last, csub_e, rsub_e;
    logic [COLW-1:0]    col_e, col_sel;
    logic [ROWW-1:0]    row_e;
    logic               new_line, swap_now;
    logic [TW-1:0]      texel;

    assign x11    = {1'b0, X_VGA};
    assign y11    = {1'b0, Y_VGA};
    assign xs11   = {1'b0, xs_q};
    assign ys11   = {1'b0, ys_q};
    assign span_x = 11'(SPR_W) * 11'(m_q);
    assign span_y = 11'(SPR_H) * 11'(m_q);
    assign m_last = m_q - SCALE_W'(1);

    // Until a FRAME_START arrives after reset nothing may match the window.
    assign win_d = PIX_VALID && frame_ok_q
                && (x11 >= xs11) && (x11 < xs11 + span_x)
                && (y11 >= ys11) && (y11 < ys11 + span_y);

    assign new_line = !line_seen_q || (Y_VGA != line_y_q);
    assign swap_now = FRAME_START && (pend_q || SWAP_REQ);
    assign texel    = front_q ? bank1[addr_q] : bank0[addr_q];

    always_comb begin
        col_e  = col_q;
        csub_e = csub_q;
        row_e  = row_q;
        rsub_e = rsub_q;
        if (new_line) begin
            col_e  = '0;
            csub_e = '0;
            if (line_seen_q) begin
                if (rsub_q == m_last) begin
                    rsub_e = '0;
                    row_e  = row_q + ROWW'(1);
                end else begin
                    rsub_e = rsub_q + SCALE_W'(1);
                end
            end
        end
        col_sel = flip_q ? COLW'(SPR_W - 1) - col_e : col_e;
    end

    always_comb begin
        xs_d        = xs_q;
        ys_d        = ys_q;
        m_d         = m_q;
        flip_d      = flip_q;
        ten_d       = ten_q;
        key_d       = key_q;
        frame_ok_d  = frame_ok_q;
        front_d     = front_q;
        pend_d      = pend_q;
        col_d       = col_q;
        row_d       = row_q;
        csub_d      = csub_q;
        rsub_d      = rsub_q;
        line_y_d    = line_y_q;
        line_seen_d = line_seen_q;
        addr_d      = '0;
        if (win_d) begin
            addr_d = AW'(row_e) * AW'(SPR_W) + AW'(col_sel);
        end
        if (FRAME_START) begin
            xs_d        = X_OBJETO;
            ys_d        = Y_OBJETO;
            m_d         = (MULTIPLICADOR == '0) ? SCALE_W'(1) : MULTIPLICADOR;
            flip_d      = FLIP_H;
            ten_d       = TRANSP_EN;
            key_d       = TRANSP_KEY;
            frame_ok_d  = 1'b1;
            col_d       = '0;
            row_d       = '0;
            csub_d      = '0;
            rsub_d      = '0;
            line_seen_d = 1'b0;
        end else if (win_d) begin
            row_d       = row_e;
            rsub_d      = rsub_e;
            line_y_d    = Y_VGA;
            line_seen_d = 1'b1;
            if (csub_e == m_last) begin
                csub_d = '0;
                col_d  = col_e + COLW'(1);
            end else begin
                csub_d = csub_e + SCALE_W'(1);
                col_d  = col_e;
            end
        end
        if (swap_now) begin
            front_d = !front_q;
            pend_d  = 1'b0;
        end else if (SWAP_REQ) begin
            pend_d = 1'b1;
        end
        rgb_d = '0;
        hit_d = 1'b0;
        if (win_q && !(ten_q && (texel == key_q))) begin
            rgb_d = texel;
            hit_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            xs_q        <= '0;
            ys_q        <= '0;
            m_q         <= SCALE_W'(1);
            flip_q      <= 1'b0;
            ten_q       <= 1'b0;
            key_q       <= '0;
            frame_ok_q  <= 1'b0;
            front_q     <= 1'b0;
            pend_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            csub_q      <= '0;
            rsub_q      <= '0;
            line_y_q    <= '0;
            line_seen_q <= 1'b0;
            win_q       <= 1'b0;
            addr_q      <= '0;
            rgb_q       <= '0;
            hit_q       <= 1'b0;
        end else begin
            xs_q        <= xs_d;
            ys_q        <= ys_d;
            m_q         <= m_d;
            flip_q      <= flip_d;
            ten_q       <= ten_d;
            key_q       <= key_d;
            frame_ok_q  <= frame_ok_d;
            front_q     <= front_d;
            pend_q      <= pend_d;
            col_q       <= col_d;
            row_q       <= row_d;
            csub_q      <= csub_d;
            rsub_q      <= rsub_d;
            line_y_q    <= line_y_d;
            line_seen_q <= line_seen_d;
            win_q       <= win_d;
            addr_q      <= addr_d;
            rgb_q       <= rgb_d;
            hit_q       <= hit_d;
        end
    end

    // Texel storage keeps its contents across reset; writes target the pre-swap back bank.
    always_ff @(posedge CLK) begin
        if (WR_EN && ({1'b0, WR_ADDR} < (AW + 1)'(N))) begin
            if (front_q) begin
                bank0[WR_ADDR] <= WR_DATA;
            end else begin
                bank1[WR_ADDR] <= WR_DATA;
            end
        end
    end

    assign R_VGA        = rgb_q[3*CW-1:2*CW];
    assign G_VGA        = rgb_q[2*CW-1:CW];
    assign B_VGA        = rgb_q[CW-1:0];
    assign HIT          = hit_q;
    assign SWAP_PENDING = pend_q;
endmodule
